// File: rtl/fbcpu_pkg.sv
// Shared types and defaults for the FB-CPU boot/reload controller.
// Holds the loader state enum, default RAM geometry and release length.
package fbcpu_pkg;

    localparam int LDR_ADDRESS_WIDTH = 6;
    localparam int LDR_DATA_WIDTH    = 10;
    localparam int RELEASE_CYCLES    = 2;

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_LOAD,
        ST_RELEASE,
        ST_RUN,
        ST_ERR
    } ldr_state_t;

endpackage

// File: rtl/fbcpu_loader.sv
// Boot/reload controller: holds the FB-CPU in reset, streams an image into
// RAM words 0..N-1 over valid/ready, releases the core, then muxes the RAM
// port to the core. A new load_start aborts the running program and reloads.
//
// Ports:
//   clk, rst              clock, async active-low reset
//   load_start, run_start start a (re)load / release without loading
//   ld_valid/ld_data/ld_last, ld_ready   image source handshake
//   cpu_rst               active-high reset to the core
//   cpu_mar/cpu_mdr_in/cpu_ram_wr        core RAM request
//   ram_addr/ram_din/ram_we              RAM port
//   load_count, load_done, load_err      load status
module fbcpu_loader
    import fbcpu_pkg::*;
#(
    parameter int ADDRESS_WIDTH = LDR_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = LDR_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_start,
    input  logic                     run_start,
    input  logic                     ld_valid,
    input  logic [DATA_WIDTH-1:0]    ld_data,
    input  logic                     ld_last,
    output logic                     ld_ready,
    output logic                     cpu_rst,
    input  logic [ADDRESS_WIDTH-1:0] cpu_mar,
    input  logic [DATA_WIDTH-1:0]    cpu_mdr_in,
    input  logic                     cpu_ram_wr,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]    ram_din,
    output logic                     ram_we,
    output logic [ADDRESS_WIDTH:0]   load_count,
    output logic                     load_done,
    output logic                     load_err
);

    localparam int CW = ADDRESS_WIDTH + 1;
    localparam int RW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

    // Count value just before the accept that fills the last RAM word.
    localparam logic [CW-1:0] LAST_SLOT = CW'((1 << ADDRESS_WIDTH) - 1);
    localparam logic [RW-1:0] REL_LAST  = RW'(RELEASE_CYCLES - 1);

    ldr_state_t      r_state;
    ldr_state_t      w_next;
    logic [CW-1:0]   r_load_count;
    logic            r_load_err;
    logic            r_load_done;
    logic            r_from_load;
    logic [RW-1:0]   r_rel_cnt;
    logic            w_accept;
    logic            w_enter_load;
    logic            w_enter_rel;

    assign w_accept     = (r_state == ST_LOAD) && ld_valid;
    assign w_enter_load = (w_next == ST_LOAD) && (r_state != ST_LOAD);
    assign w_enter_rel  = (w_next == ST_RELEASE) && (r_state != ST_RELEASE);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_HOLD: begin
                if (load_start)
                    w_next = ST_LOAD;
                else if (run_start)
                    w_next = ST_RELEASE;
            end
            ST_LOAD: begin
                // load_start is deliberately ignored while streaming.
                if (w_accept) begin
                    if (ld_last)
                        w_next = ST_RELEASE;
                    else if (r_load_count == LAST_SLOT)
                        w_next = ST_ERR;
                end
            end
            ST_RELEASE: begin
                if (load_start)
                    w_next = ST_LOAD;
                else if (r_rel_cnt == REL_LAST)
                    w_next = ST_RUN;
            end
            ST_RUN: begin
                if (load_start)
                    w_next = ST_LOAD;
            end
            ST_ERR: begin
                if (load_start)
                    w_next = ST_LOAD;
            end
            default: w_next = ST_HOLD;
        endcase
    end

    // RAM port: loader owns it on accepts, core owns it in RUN, idle otherwise.
    always_comb begin
        ld_ready = 1'b0;
        cpu_rst  = 1'b1;
        ram_addr = '0;
        ram_din  = '0;
        ram_we   = 1'b0;
        unique case (r_state)
            ST_LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    ram_we   = 1'b1;
                    ram_addr = r_load_count[ADDRESS_WIDTH-1:0];
                    ram_din  = ld_data;
                end
            end
            ST_RUN: begin
                cpu_rst  = 1'b0;
                ram_addr = cpu_mar;
                ram_din  = cpu_mdr_in;
                ram_we   = cpu_ram_wr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_HOLD;
            r_load_count <= '0;
            r_load_err   <= 1'b0;
            r_load_done  <= 1'b0;
            r_from_load  <= 1'b0;
            r_rel_cnt    <= '0;
        end else begin
            r_state <= w_next;

            r_load_done <= (r_state == ST_RELEASE) && (w_next == ST_RUN)
                           && r_from_load;

            if (w_enter_load)
                r_load_count <= '0;
            else if (w_accept)
                r_load_count <= r_load_count + 1'b1;

            if (w_enter_load)
                r_load_err <= 1'b0;
            else if (w_next == ST_ERR)
                r_load_err <= 1'b1;

            // Remember whether this release follows a load (for load_done).
            if (w_enter_rel) begin
                r_rel_cnt   <= '0;
                r_from_load <= (r_state == ST_LOAD);
            end else if (r_state == ST_RELEASE) begin
                r_rel_cnt <= r_rel_cnt + 1'b1;
            end
        end
    end

    assign load_count = r_load_count;
    assign load_done  = r_load_done;
    assign load_err   = r_load_err;

endmodule
